// File: rtl/noc_perf_monitor_pkg.sv
// Shared types and sizing for the NoC performance monitor.
// Mesh geometry, counter bank selectors and monitor FSM states.
package noc_perf_monitor_pkg;

    localparam int MESH_SIZE = 2;
    localparam int PE_NUMBER = MESH_SIZE * MESH_SIZE;

    typedef enum logic [1:0] {
        STALL    = 2'd0,
        CONFLICT = 2'd1,
        FINISH   = 2'd2,
        TOTAL    = 2'd3
    } perf_bank_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic saturated;

    assign saturated = &count;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !saturated) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/noc_perf_monitor.sv
// Per-PE stall/conflict/finish counters for one NoC layer run,
// with a pipelined single-cycle read port.
module noc_perf_monitor #(
    parameter  int PE_NUMBER = noc_perf_monitor_pkg::PE_NUMBER,
    parameter  int CNT_W     = 32,
    localparam int IDX_W     = noc_perf_monitor_pkg::idx_width(PE_NUMBER)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic [PE_NUMBER-1:0] pe_stall,
    input  logic [PE_NUMBER-1:0] router_conflict,
    input  logic [PE_NUMBER-1:0] pe_done,
    input  logic                 layer_finished,
    input  logic                 rd_req,
    input  logic [1:0]           rd_sel,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 rd_err,
    output logic                 busy,
    output logic                 meas_done
);

    import noc_perf_monitor_pkg::*;

    perf_state_e      state;
    logic             run_cnt;
    logic [CNT_W-1:0] cycle_cc;
    logic [CNT_W-1:0] cycle_next;
    logic [CNT_W-1:0] stall_cc    [PE_NUMBER];
    logic [CNT_W-1:0] conflict_cc [PE_NUMBER];
    logic [CNT_W-1:0] finish_cc   [PE_NUMBER];
    perf_bank_e       rd_bank;
    logic [CNT_W-1:0] rd_val;
    logic             rd_oor;

    // start wins over everything, so a clearing cycle never counts
    assign run_cnt = (state == RUN) && !start;

    // value cycle_cc takes at this edge; doubles as the finish stamp
    assign cycle_next = (&cycle_cc) ? cycle_cc : cycle_cc + CNT_W'(1);

    perf_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle (
        .clk   (clk),
        .arst  (arst),
        .clr   (start),
        .inc   (run_cnt),
        .count (cycle_cc)
    );

    for (genvar g = 0; g < PE_NUMBER; g++) begin : g_pe
        perf_sat_counter #(
            .CNT_W (CNT_W)
        ) u_stall (
            .clk   (clk),
            .arst  (arst),
            .clr   (start),
            .inc   (run_cnt && pe_stall[g]),
            .count (stall_cc[g])
        );

        perf_sat_counter #(
            .CNT_W (CNT_W)
        ) u_conflict (
            .clk   (clk),
            .arst  (arst),
            .clr   (start),
            .inc   (run_cnt && router_conflict[g]),
            .count (conflict_cc[g])
        );
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            meas_done <= 1'b0;
        end else if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            meas_done <= 1'b0;
        end else if (state == RUN && layer_finished) begin
            state     <= DONE;
            busy      <= 1'b0;
            meas_done <= 1'b1;
        end
    end

    // a zero stamp means "not finished yet"; layer end fills the rest
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < PE_NUMBER; i++) begin
                finish_cc[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < PE_NUMBER; i++) begin
                finish_cc[i] <= '0;
            end
        end else if (run_cnt) begin
            for (int i = 0; i < PE_NUMBER; i++) begin
                if (finish_cc[i] == '0 && (pe_done[i] || layer_finished)) begin
                    finish_cc[i] <= cycle_next;
                end
            end
        end
    end

    assign rd_bank = perf_bank_e'(rd_sel);

    always_comb begin
        rd_val = '0;
        rd_oor = 1'b0;
        if (rd_bank == TOTAL) begin
            rd_val = cycle_cc;
        end else if (int'(rd_idx) >= PE_NUMBER) begin
            rd_oor = 1'b1;
        end else begin
            for (int i = 0; i < PE_NUMBER; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    case (rd_bank)
                        STALL:    rd_val = stall_cc[i];
                        CONFLICT: rd_val = conflict_cc[i];
                        FINISH:   rd_val = finish_cc[i];
                        default:  rd_val = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_val;
                rd_err  <= rd_oor;
            end
        end
    end

endmodule

// File: tb/tb_noc_perf_monitor.sv
// Scoreboard bench: two monitor instances (4 PEs/32-bit and 5 PEs/4-bit)
// driven in lockstep and compared against an abstract counting model.
module tb_noc_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst, start, lf, rd_req;
    logic [4:0] stall_v, conf_v, done_v;
    logic [1:0] rd_sel;
    logic [2:0] rd_idx;

    logic        rdv_a, rde_a, busy_a, md_a;
    logic [31:0] rdd_a;
    logic        rdv_b, rde_b, busy_b, md_b;
    logic [3:0]  rdd_b;

    noc_perf_monitor #(.PE_NUMBER(4), .CNT_W(32)) dut_a (
        .clk             (clk),
        .arst            (arst),
        .start           (start),
        .pe_stall        (stall_v[3:0]),
        .router_conflict (conf_v[3:0]),
        .pe_done         (done_v[3:0]),
        .layer_finished  (lf),
        .rd_req          (rd_req),
        .rd_sel          (rd_sel),
        .rd_idx          (rd_idx[1:0]),
        .rd_valid        (rdv_a),
        .rd_data         (rdd_a),
        .rd_err          (rde_a),
        .busy            (busy_a),
        .meas_done       (md_a)
    );

    noc_perf_monitor #(.PE_NUMBER(5), .CNT_W(4)) dut_b (
        .clk             (clk),
        .arst            (arst),
        .start           (start),
        .pe_stall        (stall_v),
        .router_conflict (conf_v),
        .pe_done         (done_v),
        .layer_finished  (lf),
        .rd_req          (rd_req),
        .rd_sel          (rd_sel),
        .rd_idx          (rd_idx),
        .rd_valid        (rdv_b),
        .rd_data         (rdd_b),
        .rd_err          (rde_b),
        .busy            (busy_b),
        .meas_done       (md_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic void chk(input string n, input logic [63:0] act,
                                input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    // reference model: plain per-instance arrays of counts
    int              npe  [2] = '{4, 5};
    longint unsigned maxv [2] = '{64'hFFFF_FFFF, 64'd15};
    longint unsigned m_stall [2][5];
    longint unsigned m_conf  [2][5];
    longint unsigned m_fin   [2][5];
    longint unsigned m_tot   [2];
    int              m_st    [2];   // 0 idle, 1 measuring, 2 finished

    function automatic longint unsigned bump(input int d, input longint unsigned v);
        return (v >= maxv[d]) ? maxv[d] : v + 1;
    endfunction

    function automatic void m_clear(input int d);
        m_tot[d] = 0;
        for (int i = 0; i < 5; i++) begin
            m_stall[d][i] = 0;
            m_conf[d][i]  = 0;
            m_fin[d][i]   = 0;
        end
    endfunction

    function automatic void m_step(input int d);
        if (arst) begin
            m_clear(d);
            m_st[d] = 0;
        end else if (start) begin
            m_clear(d);
            m_st[d] = 1;
        end else if (m_st[d] == 1) begin
            m_tot[d] = bump(d, m_tot[d]);
            for (int i = 0; i < npe[d]; i++) begin
                if (stall_v[i]) m_stall[d][i] = bump(d, m_stall[d][i]);
                if (conf_v[i])  m_conf[d][i]  = bump(d, m_conf[d][i]);
                if (m_fin[d][i] == 0 && (done_v[i] || lf)) m_fin[d][i] = m_tot[d];
            end
            if (lf) m_st[d] = 2;
        end
    endfunction

    function automatic int eff_idx(input int d);
        return (d == 0) ? int'(rd_idx[1:0]) : int'(rd_idx);
    endfunction

    function automatic bit exp_err(input int d);
        return rd_sel != 2'd3 && eff_idx(d) >= npe[d];
    endfunction

    function automatic longint unsigned exp_data(input int d);
        int i;
        i = eff_idx(d);
        if (rd_sel == 2'd3) return m_tot[d];
        if (i >= npe[d]) return 0;
        case (rd_sel)
            2'd0:    return m_stall[d][i];
            2'd1:    return m_conf[d][i];
            default: return m_fin[d][i];
        endcase
    endfunction

    typedef struct {
        int              cyc;
        longint unsigned da;
        bit              ea;
        longint unsigned db;
        bit              eb;
    } rd_exp_t;

    typedef struct {
        int cyc;
        bit ba;
        bit ma;
        bit bb;
        bit mb;
    } st_exp_t;

    rd_exp_t rdq[$];
    st_exp_t stq[$];

    logic       s_ar, s_start, s_lf, s_rq;
    logic [4:0] s_stall, s_conf, s_done;
    logic [1:0] s_sel;
    logic [2:0] s_idx;

    task automatic step();
        rd_exp_t re;
        st_exp_t se;
        @(negedge clk);
        arst    = s_ar;
        start   = s_start;
        lf      = s_lf;
        stall_v = s_stall;
        conf_v  = s_conf;
        done_v  = s_done;
        rd_req  = s_rq;
        rd_sel  = s_sel;
        rd_idx  = s_idx;
        cyc++;
        if (s_ar) begin
            #1;
            chk("arst_busy_a", busy_a, 0);
            chk("arst_done_a", md_a, 0);
            chk("arst_valid_a", rdv_a, 0);
            chk("arst_data_a", rdd_a, 0);
            chk("arst_err_a", rde_a, 0);
            chk("arst_busy_b", busy_b, 0);
            chk("arst_data_b", rdd_b, 0);
        end
        if (s_rq && !s_ar) begin
            re.cyc = cyc;
            re.da  = exp_data(0);
            re.ea  = exp_err(0);
            re.db  = exp_data(1);
            re.eb  = exp_err(1);
            rdq.push_back(re);
        end
        m_step(0);
        m_step(1);
        se.cyc = cyc;
        se.ba  = (m_st[0] == 1);
        se.ma  = (m_st[0] == 2);
        se.bb  = (m_st[1] == 1);
        se.mb  = (m_st[1] == 2);
        stq.push_back(se);
        s_start = 1'b0;
        s_rq    = 1'b0;
    endtask

    task automatic rd(input int sel, input int idx);
        s_rq  = 1'b1;
        s_sel = 2'(sel);
        s_idx = 3'(idx);
        step();
    endtask

    task automatic dump_all();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 5; i++) rd(s, i);
        rd(3, 0);
    endtask

    task automatic quiet();
        s_lf = 0; s_stall = 0; s_conf = 0; s_done = 0;
    endtask

    // monitor: one state expectation per cycle, read responses in order
    always @(posedge clk) begin : mon
        st_exp_t se;
        rd_exp_t re;
        #1;
        if (stq.size() > 0) begin
            se = stq.pop_front();
            chk("busy_a", busy_a, se.ba);
            chk("meas_done_a", md_a, se.ma);
            chk("busy_b", busy_b, se.bb);
            chk("meas_done_b", md_b, se.mb);
            if (rdq.size() > 0 && rdq[0].cyc == se.cyc) begin
                re = rdq.pop_front();
                chk("rd_valid_a", rdv_a, 1);
                chk("rd_data_a", rdd_a, re.da);
                chk("rd_err_a", rde_a, re.ea);
                chk("rd_valid_b", rdv_b, 1);
                chk("rd_data_b", rdd_b, re.db);
                chk("rd_err_b", rde_b, re.eb);
            end else begin
                chk("rd_valid_idle_a", rdv_a, 0);
                chk("rd_valid_idle_b", rdv_b, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arst = 1; start = 0; lf = 0; rd_req = 0;
        stall_v = 0; conf_v = 0; done_v = 0; rd_sel = 0; rd_idx = 0;
        s_ar = 1; s_start = 0; s_rq = 0; s_sel = 0; s_idx = 0;
        quiet();
        for (int d = 0; d < 2; d++) begin
            m_clear(d);
            m_st[d] = 0;
        end
        #1;
        chk("reset_busy", busy_a, 0);
        chk("reset_meas_done", md_a, 0);
        chk("reset_rd_valid", rdv_a, 0);
        step();
        s_ar = 0;
        dump_all();

        // single stalling PE over an 11-cycle layer
        s_start = 1; step();
        s_stall = 5'b00001;
        repeat (10) step();
        s_lf = 1; step();
        quiet();
        dump_all();

        // one early finisher, the rest stamped at layer end
        s_start = 1; step();
        repeat (2) step();
        s_done = 5'b00100;
        repeat (5) step();
        s_lf = 1; step();
        quiet();
        dump_all();

        // long all-conflict run; 4-bit instance must pin at 15
        s_start = 1; step();
        s_conf = 5'b11111;
        repeat (20) step();
        s_lf = 1; step();
        quiet();
        dump_all();

        // start beats a simultaneous layer end
        s_start = 1; s_lf = 1; step();
        s_lf = 0;
        rd(3, 0);
        s_lf = 1; step();
        s_lf = 0;
        rd(3, 0);

        // out-of-range index, then back-to-back bank reads
        rd(0, 5);
        rd(3, 0);
        rd(1, 2);

        // asynchronous reset mid-run discards the measurement
        s_start = 1; step();
        s_stall = 5'b11111;
        repeat (5) step();
        s_ar = 1; step();
        s_ar = 0;
        repeat (4) step();
        dump_all();
        quiet();

        // randomized traffic with occasional start, layer end and reset
        for (int k = 0; k < 500; k++) begin
            s_start = ($urandom_range(0, 39) == 0);
            s_lf    = ($urandom_range(0, 29) == 0);
            s_ar    = ($urandom_range(0, 199) == 0);
            s_stall = 5'($urandom);
            s_conf  = 5'($urandom);
            s_done  = 5'($urandom) & 5'($urandom) & 5'($urandom);
            s_rq    = 1'($urandom);
            s_sel   = 2'($urandom);
            s_idx   = 3'($urandom);
            step();
        end
        s_ar = 0;
        quiet();
        dump_all();
        repeat (2) step();
        @(posedge clk);
        #2;
        chk("rd_queue_drained", rdq.size(), 0);
        chk("state_queue_drained", stq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
